// File: rtl/conv_inst_fetch_pkg.sv
// Shared defaults and FSM encoding for the conv instruction fetcher.
package conv_inst_fetch_pkg;

   localparam int IRW_D = 30;
   localparam int IN_D  = 3;
   localparam int AW_D  = 14;
   localparam int CW_D  = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

endpackage

// File: rtl/conv_inst_fetch_if.sv
// Bundle valid/ready port between the fetcher and the loop stage.
interface conv_inst_fetch_if
   import conv_inst_fetch_pkg::*;
#(
   parameter int W = IRW_D * IN_D
);

   logic [W-1:0] bndl_data;
   logic         bndl_valid;
   logic         bndl_ready;

   modport master (
      output bndl_data,
      output bndl_valid,
      input  bndl_ready
   );

   modport slave (
      input  bndl_data,
      input  bndl_valid,
      output bndl_ready
   );

endinterface

// File: rtl/conv_inst_fetch.sv
// Reads instruction words from SRAM and packs IN of them per bundle
// onto a registered valid/ready output.
module conv_inst_fetch
   import conv_inst_fetch_pkg::*;
#(
   parameter int IRW = IRW_D,
   parameter int IN  = IN_D,
   parameter int AW  = AW_D,
   parameter int CW  = CW_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [AW-1:0]     start_addr,
   input  logic [CW-1:0]     bndl_num,
   output logic              busy,
   output logic              done,
   output logic              mem_en,
   output logic [AW-1:0]     mem_addr,
   input  logic [IRW-1:0]    mem_rdata,
   conv_inst_fetch_if.master bndl
);

   localparam int WCW = $clog2(IN + 1);

   state_t state, state_nxt;

   logic [CW-1:0]      num;
   logic [CW-1:0]      bi;
   logic [CW-1:0]      bo;
   logic [WCW-1:0]     wcnt;
   logic [WCW-1:0]     wbase;
   logic [WCW-1:0]     wnext;
   logic [AW-1:0]      addr;
   logic               rd_v;
   logic [WCW-1:0]     rd_k;
   logic [IRW-1:0]     slot [IN];
   logic               full;
   logic               hs;
   logic               last_in;
   logic               move;
   logic               issue;
   logic               go;
   logic [IRW*IN-1:0]  asm_data;

   assign hs      = bndl.bndl_valid & bndl.bndl_ready;
   assign last_in = rd_v && (rd_k == WCW'(IN - 1));
   // The last word can bypass the buffer straight into the output register.
   assign move    = (last_in || full) && (!bndl.bndl_valid || hs);
   assign issue   = (state == RUN) && (bi < num) &&
                    ((wcnt < WCW'(IN)) || move);
   assign wbase   = (wcnt == WCW'(IN)) ? '0 : wcnt;
   assign wnext   = wbase + WCW'(1);
   assign go      = (state == IDLE) && start;
   assign mem_en  = issue;
   assign mem_addr = addr;

   always_comb begin
      asm_data = '0;
      for (int k = 0; k < IN; k++) begin
         if (k == IN - 1 && !full)
            asm_data[k*IRW +: IRW] = mem_rdata;
         else
            asm_data[k*IRW +: IRW] = slot[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start) state_nxt = (bndl_num == '0) ? FIN : RUN;
         RUN:  if (hs && bo == num - CW'(1)) state_nxt = FIN;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         IDLE: ;
         RUN:  busy = 1'b1;
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num  <= '0;
         bi   <= '0;
         bo   <= '0;
         wcnt <= '0;
         addr <= '0;
      end else if (go) begin
         num  <= bndl_num;
         bi   <= '0;
         bo   <= '0;
         wcnt <= '0;
         addr <= start_addr;
      end else begin
         if (hs) bo <= bo + CW'(1);
         if (issue) begin
            addr <= addr + AW'(1);
            wcnt <= wnext;
            if (wnext == WCW'(IN)) bi <= bi + CW'(1);
         end else if (move && wcnt == WCW'(IN)) begin
            wcnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v <= 1'b0;
         rd_k <= '0;
         full <= 1'b0;
         for (int k = 0; k < IN; k++) slot[k] <= '0;
      end else begin
         rd_v <= issue;
         if (issue) rd_k <= wbase;
         if (rd_v) slot[rd_k] <= mem_rdata;
         if (move)         full <= 1'b0;
         else if (last_in) full <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bndl.bndl_data  <= '0;
         bndl.bndl_valid <= 1'b0;
      end else if (move) begin
         bndl.bndl_data  <= asm_data;
         bndl.bndl_valid <= 1'b1;
      end else if (hs) begin
         bndl.bndl_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_inst_fetch.sv
// Randomized bench for conv_inst_fetch against a queue-based model.
module tb_conv_inst_fetch;
   import conv_inst_fetch_pkg::*;

   localparam int IRW = IRW_D;
   localparam int IN  = IN_D;
   localparam int AW  = AW_D;
   localparam int CW  = CW_D;
   localparam int W   = IRW * IN;
   localparam int MSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [CW-1:0] bndl_num = '0;
   logic          busy, done, mem_en;
   logic [AW-1:0] mem_addr;
   logic [IRW-1:0] mem_rdata = '0;

   conv_inst_fetch_if bif ();

   conv_inst_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .bndl_num   (bndl_num),
      .busy       (busy),
      .done       (done),
      .mem_en     (mem_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .bndl       (bif.master)
   );

   always #5 clk = ~clk;

   logic [IRW-1:0] mem [MSZ];

   always @(posedge clk)
      if (mem_en) mem_rdata <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [W-1:0]  exp_q [$];
   logic [AW-1:0] addr_q [$];
   int            rd_cyc [$];
   int n_rd, n_busy, n_done, n_hs;
   int start_cyc, done_cyc, first_valid_cyc, last_hs_cyc;
   logic          stall_prev;
   logic [W-1:0]  data_prev;

   // Reference: bundle b word k comes from start_addr + b*IN + k (mod 2^AW).
   task automatic plan(input logic [AW-1:0] a, input int n);
      logic [W-1:0] v;
      int idx;
      exp_q.delete();
      addr_q.delete();
      for (int b = 0; b < n; b++) begin
         v = '0;
         for (int k = 0; k < IN; k++) begin
            idx = (int'(a) + b * IN + k) % MSZ;
            v[k*IRW +: IRW] = mem[idx];
            addr_q.push_back(AW'(idx));
         end
         exp_q.push_back(v);
      end
   endtask

   initial begin
      stall_prev = 1'b0;
      data_prev = '0;
      n_rd = 0; n_busy = 0; n_done = 0; n_hs = 0;
      start_cyc = 0; done_cyc = 0; first_valid_cyc = -1; last_hs_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
            continue;
         end
         if (mem_en) begin
            n_rd++;
            rd_cyc.push_back(cyc);
            chk("rd_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) chk("rd_addr", mem_addr, addr_q.pop_front());
         end
         if (stall_prev) begin
            chk("hold_valid", bif.bndl_valid, 1);
            chk("hold_data", bif.bndl_data, data_prev);
         end
         stall_prev = bif.bndl_valid && !bif.bndl_ready;
         data_prev = bif.bndl_data;
         if (bif.bndl_valid && bif.bndl_ready) begin
            n_hs++;
            last_hs_cyc = cyc;
            chk("bndl_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("bndl_data", bif.bndl_data, exp_q.pop_front());
         end
         if (bif.bndl_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (busy) n_busy++;
         if (start && !busy) start_cyc = cyc;
      end
   end

   task automatic chk_zero(input string p);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_mem_en"}, mem_en, 0);
      chk({p, "_mem_addr"}, mem_addr, 0);
      chk({p, "_valid"}, bif.bndl_valid, 0);
      chk({p, "_data"}, bif.bndl_data, 0);
   endtask

   // mode 0: ready=1, 1: random ready, 2: stall 12 cycles after first valid,
   // 3: random ready plus a stray start mid-run
   task automatic do_run(input logic [AW-1:0] a, input int n, input int mode);
      int d0, budget, hold;
      plan(a, n);
      d0 = n_done;
      n_rd = 0;
      n_busy = 0;
      rd_cyc.delete();
      first_valid_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1;
      start_addr = a;
      bndl_num = CW'(n);
      bif.bndl_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start = 1'b0;
      start_addr = AW'($urandom);
      bndl_num = CW'($urandom);
      budget = 0;
      hold = 0;
      while (n_done == d0 && budget < 5000) begin
         start = 1'b0;
         case (mode)
            0: bif.bndl_ready = 1'b1;
            2: begin
               if (first_valid_cyc < 0) bif.bndl_ready = 1'b0;
               else if (hold < 12) begin
                  bif.bndl_ready = 1'b0;
                  hold++;
               end else if (hold == 12) begin
                  chk("t2_reads_paused", n_rd, 2 * IN);
                  chk("t2_mem_en_low", mem_en, 0);
                  bif.bndl_ready = 1'b1;
                  hold++;
               end
            end
            default: begin
               bif.bndl_ready = 1'($urandom_range(0, 1));
               if (mode == 3 && budget == 4) begin
                  start = 1'b1;
                  start_addr = AW'($urandom);
                  bndl_num = CW'($urandom_range(1, 9));
               end
            end
         endcase
         @(posedge clk); #1;
         budget++;
      end
      start = 1'b0;
      chk("done_reached", n_done - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("one_done", n_done - d0, 1);
      chk("idle_busy", busy, 0);
      chk("bndl_left", exp_q.size(), 0);
      chk("addr_left", addr_q.size(), 0);
   endtask

   initial begin
      int d0;
      bif.bndl_ready = 1'b0;
      for (int i = 0; i < MSZ; i++) mem[i] = IRW'(i);
      repeat (2) @(negedge clk);
      chk_zero("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_run(AW'(16'h010), 2, 0);
      chk("t1_nrd", n_rd, 2 * IN);
      if (rd_cyc.size() == 2 * IN) chk("t1_consecutive", rd_cyc[2*IN-1] - rd_cyc[0], 2 * IN - 1);
      chk("t1_latency", first_valid_cyc - (start_cyc + 1), IN + 1);
      chk("t1_done_after_hs", done_cyc - last_hs_cyc, 1);

      do_run(AW'(16'h010), 4, 2);
      chk("t2_nrd", n_rd, 4 * IN);

      do_run(AW'(16'h123), 0, 0);
      chk("t3_nrd", n_rd, 0);
      chk("t3_busy_cycles", n_busy, 1);
      chk("t3_done_lat", done_cyc - start_cyc, 1);

      do_run(AW'(16'h3FFE), 1, 0);
      chk("t4_nrd", n_rd, IN);

      do_run(AW'(16'h200), 10, 3);

      plan(AW'(16'h050), 20);
      @(posedge clk); #1;
      start = 1'b1;
      start_addr = AW'(16'h050);
      bndl_num = CW'(20);
      bif.bndl_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      d0 = n_done;
      @(negedge clk);
      chk_zero("midrst");
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_done", n_done - d0, 0);
      chk("midrst_idle", busy, 0);
      do_run(AW'(16'h300), 3, 0);

      for (int i = 0; i < MSZ; i++) mem[i] = IRW'($urandom);
      do_run(AW'($urandom), 200, 1);
      for (int r = 0; r < 4; r++)
         do_run(AW'($urandom), $urandom_range(0, 15), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
